// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: opcode/funct constants, state and aluop encodings, ALU control codes.
package mc_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_COP1  = 6'b010001;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB,
    FPEX, FPWB, BEQEX, ADDIEX, ADDIWB, JEX, BNEEX
  } state_t;
  typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FN = 2'b10} aluop_t;
  localparam logic [2:0] AC_AND = 3'b000;
  localparam logic [2:0] AC_OR  = 3'b001;
  localparam logic [2:0] AC_ADD = 3'b010;
  localparam logic [2:0] AC_SUB = 3'b110;
  localparam logic [2:0] AC_SLT = 3'b111;
endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: (aluop, funct) -> zero-extended alucontrol plus bad_funct flag.
module mc_aludec
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W      = 6,
  parameter int ALUCTRL_W = 3
) (
  input  aluop_t               aluop,
  input  logic [OP_W-1:0]      funct,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 bad_funct
);
  logic [2:0] fcode;
  always_comb begin
    fcode = AC_SLT;
    bad_funct = 1'b0;
    case (funct)
      OP_W'(FN_ADD): fcode = AC_ADD;
      OP_W'(FN_SUB): fcode = AC_SUB;
      OP_W'(FN_AND): fcode = AC_AND;
      OP_W'(FN_OR):  fcode = AC_OR;
      OP_W'(FN_SLT): fcode = AC_SLT;
      default:       bad_funct = (aluop == ALUOP_FN);
    endcase
  end
  assign alucontrol = ALUCTRL_W'(aluop == ALUOP_ADD ? AC_ADD : aluop == ALUOP_SUB ? AC_SUB : fcode);
endmodule

// File: rtl/mc_controller_v2.sv
// mc_controller_v2: multicycle MIPS Moore control FSM with memory wait states.
// Define BNE_EN to decode op 000101 as bne (otherwise it is flagged illegal).
module mc_controller_v2
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W      = 6,
  parameter int ALUCTRL_W = 3,
  parameter int STATE_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OP_W-1:0]      op,
  input  logic [OP_W-1:0]      funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pcen,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regwrite_int,
  output logic                 regwrite_float,
  output logic                 alusrca,
  output logic                 iord,
  output logic                 memtoreg,
  output logic                 regdst,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal_op
);
  logic [STATE_W-1:0] state;
  state_t st, nxt;
  aluop_t aluop;
  logic pcwrite, branch, bne, irw, mw, rwi, rwf, bad_op, bad_funct;
  assign st = state_t'(state[3:0]);
  always_ff @(posedge clk) state <= reset ? STATE_W'(FETCH) : STATE_W'(nxt);
  always_comb begin
    nxt = FETCH;
    pcwrite = 1'b0;
    branch = 1'b0;
    bne = 1'b0;
    irw = 1'b0;
    mw = 1'b0;
    rwi = 1'b0;
    rwf = 1'b0;
    bad_op = 1'b0;
    alusrca = 1'b0;
    iord = 1'b0;
    memtoreg = 1'b0;
    regdst = 1'b0;
    alusrcb = 2'b00;
    pcsrc = 2'b00;
    aluop = ALUOP_ADD;
    case (st)
      FETCH: begin
        alusrcb = 2'b01;
        irw = mem_ready;
        pcwrite = mem_ready;
        nxt = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        if (op == OP_W'(OP_LW) || op == OP_W'(OP_SW)) nxt = MEMADR;
        else if (op == OP_W'(OP_RTYPE)) nxt = RTYPEEX;
        else if (op == OP_W'(OP_COP1)) nxt = FPEX;
        else if (op == OP_W'(OP_BEQ)) nxt = BEQEX;
        else if (op == OP_W'(OP_ADDI)) nxt = ADDIEX;
        else if (op == OP_W'(OP_J)) nxt = JEX;
`ifdef BNE_EN
        else if (op == OP_W'(OP_BNE)) nxt = BNEEX;
`endif
        else bad_op = 1'b1;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt = (op == OP_W'(OP_SW)) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord = 1'b1;
        nxt = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        rwi = 1'b1;
      end
      MEMWR: begin
        iord = 1'b1;
        mw = 1'b1;
        nxt = mem_ready ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop = ALUOP_FN;
        nxt = RTYPEWB;
      end
      RTYPEWB: begin
        regdst = 1'b1;
        rwi = 1'b1;
      end
      FPEX: begin
        alusrca = 1'b1;
        aluop = ALUOP_FN;
        nxt = FPWB;
      end
      FPWB: begin
        regdst = 1'b1;
        rwf = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop = ALUOP_SUB;
        branch = 1'b1;
        pcsrc = 2'b01;
      end
`ifdef BNE_EN
      BNEEX: begin
        alusrca = 1'b1;
        aluop = ALUOP_SUB;
        branch = 1'b1;
        bne = 1'b1;
        pcsrc = 2'b01;
      end
`endif
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt = ADDIWB;
      end
      ADDIWB: rwi = 1'b1;
      JEX: begin
        pcsrc = 2'b10;
        pcwrite = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end
  mc_aludec #(.OP_W(OP_W), .ALUCTRL_W(ALUCTRL_W)) u_aludec (
    .aluop(aluop), .funct(funct), .alucontrol(alucontrol), .bad_funct(bad_funct)
  );
  // reset suppresses every write so an abandoned instruction leaves no trace
  assign pcen = ~reset & (pcwrite | (branch & (zero ^ bne)));
  assign memwrite = ~reset & mw;
  assign irwrite = ~reset & irw;
  assign regwrite_int = ~reset & rwi;
  assign regwrite_float = ~reset & rwf;
  assign illegal_op = ~reset & (bad_op | bad_funct);
endmodule

// File: tb/tb_mc_controller_v2.sv
// tb_mc_controller_v2: per-instruction table vectors, reset corner sequence, randomized model check.
module tb_mc_controller_v2;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b1;
  logic [5:0] op = '0, funct = '0;
  logic pcen, memwrite, irwrite, regwrite_int, regwrite_float, alusrca, iord, memtoreg, regdst, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  int checks = 0, errors = 0;

  typedef struct packed {
    logic [7:0] ir_cnt, ir_at, pc_cnt, br_src, rwi, rwf, mw, ill, alu, wb, both;
  } res_t;
  typedef struct {
    logic [5:0] op, fn;
    int f, m;
    logic z;
    int n;
    res_t e;
  } vec_t;
  vec_t tbl[$];

  mc_controller_v2 dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite_int(regwrite_int),
    .regwrite_float(regwrite_float), .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg),
    .regdst(regdst), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic res_t mk(input int at, pc, src, rwi, rwf, mw, ill, alu, wb);
    res_t r;
    r = '0;
    r.ir_cnt = 8'd1;
    r.ir_at = 8'(at);
    r.pc_cnt = 8'(pc);
    r.br_src = 8'(src);
    r.rwi = 8'(rwi);
    r.rwf = 8'(rwf);
    r.mw = 8'(mw);
    r.ill = 8'(ill);
    r.alu = 8'(alu);
    r.wb = 8'(wb);
    return r;
  endfunction

  task automatic add(input logic [5:0] o, fn, input int f, m, input logic z, input int n, input res_t e);
    vec_t v;
    v.op = o; v.fn = fn; v.f = f; v.m = m; v.z = z; v.n = n; v.e = e;
    tbl.push_back(v);
  endtask

  // instruction-level reference: cycle count and write-enable tallies per instruction
  task automatic model(input logic [5:0] o, fn, input int f, m, input logic z, output int n, output res_t e);
    bit lw, sw, rt, fp, beq, bne, addi, j, bad_fn;
    int alu_fn;
    lw = (o == 6'b100011); sw = (o == 6'b101011); rt = (o == 6'b000000); fp = (o == 6'b010001);
    beq = (o == 6'b000100); addi = (o == 6'b001000); j = (o == 6'b000010);
`ifdef BNE_EN
    bne = (o == 6'b000101);
`else
    bne = 1'b0;
`endif
    bad_fn = 1'b0;
    case (fn)
      6'b100000: alu_fn = 2;
      6'b100010: alu_fn = 6;
      6'b100100: alu_fn = 0;
      6'b100101: alu_fn = 1;
      6'b101010: alu_fn = 7;
      default: begin alu_fn = 7; bad_fn = 1'b1; end
    endcase
    e = '0;
    e.ir_cnt = 8'd1;
    e.ir_at = 8'(f);
    if (lw) begin n = f + 5 + m; e.rwi = 1; e.wb = 1; e.alu = 2; end
    else if (sw) begin n = f + 4 + m; e.mw = 8'(m + 1); e.alu = 2; end
    else if (rt || fp) begin
      n = f + 4; e.alu = 8'(alu_fn); e.wb = 2; e.ill = 8'(bad_fn);
      if (rt) e.rwi = 1; else e.rwf = 1;
    end
    else if (addi) begin n = f + 4; e.rwi = 1; e.alu = 2; end
    else if (beq || bne) begin n = f + 3; e.alu = 6; end
    else if (j) begin n = f + 3; e.alu = 2; end
    else begin n = f + 2; e.ill = 1; end
    e.pc_cnt = 8'(1 + (j ? 1 : 0) + ((beq && z) || (bne && !z) ? 1 : 0));
    e.br_src = j ? 8'd2 : ((beq && z) || (bne && !z)) ? 8'd1 : 8'd0;
  endtask

  // caller is just past a posedge; returns just past a posedge
  task automatic run(input logic [5:0] o, fn, input int f, m, input logic z, input int n, output res_t r);
    bit is_mem;
    is_mem = (o == 6'b100011) || (o == 6'b101011);
    r = '0;
    for (int c = 0; c < n; c++) begin
      op = o;
      funct = fn;
      if (c <= f) mem_ready = (c == f);
      else if (is_mem && c >= f + 3 && c <= f + 3 + m) mem_ready = (c == f + 3 + m);
      else mem_ready = 1'($urandom);
      zero = (c == f + 2) ? z : 1'($urandom);
      @(negedge clk);
      if (irwrite) begin r.ir_cnt += 8'd1; r.ir_at = 8'(c); end
      if (pcen) r.pc_cnt += 8'd1;
      if (pcen && !irwrite) r.br_src = {6'd0, pcsrc};
      if (regwrite_int) r.rwi += 8'd1;
      if (regwrite_float) r.rwf += 8'd1;
      if (regwrite_int || regwrite_float) r.wb = {6'd0, regdst, memtoreg};
      if (regwrite_int && regwrite_float) r.both += 8'd1;
      if (memwrite) r.mw += 8'd1;
      if (illegal_op) r.ill += 8'd1;
      if (c == f + 2) r.alu = {5'd0, alucontrol};
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    res_t r, e;
    int n;
    logic [5:0] o, fn;
    int f, m;
    logic z;
    logic [5:0] fns[5];
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    add(6'b100011, 6'b000000, 0, 0, 0, 5,  mk(0, 1, 0, 1, 0, 0, 0, 2, 1));
    add(6'b100011, 6'b000000, 2, 3, 0, 10, mk(2, 1, 0, 1, 0, 0, 0, 2, 1));
    add(6'b101011, 6'b000000, 0, 0, 1, 4,  mk(0, 1, 0, 0, 0, 1, 0, 2, 0));
    add(6'b101011, 6'b000000, 1, 2, 0, 7,  mk(1, 1, 0, 0, 0, 3, 0, 2, 0));
    add(6'b000000, 6'b100000, 0, 0, 0, 4,  mk(0, 1, 0, 1, 0, 0, 0, 2, 2));
    add(6'b000000, 6'b100101, 1, 0, 1, 5,  mk(1, 1, 0, 1, 0, 0, 0, 1, 2));
    add(6'b000000, 6'b101010, 0, 0, 0, 4,  mk(0, 1, 0, 1, 0, 0, 0, 7, 2));
    add(6'b010001, 6'b100010, 0, 0, 0, 4,  mk(0, 1, 0, 0, 1, 0, 0, 6, 2));
    add(6'b010001, 6'b100100, 0, 0, 1, 4,  mk(0, 1, 0, 0, 1, 0, 0, 0, 2));
    add(6'b000100, 6'b000000, 0, 0, 1, 3,  mk(0, 2, 1, 0, 0, 0, 0, 6, 0));
    add(6'b000100, 6'b000000, 0, 0, 0, 3,  mk(0, 1, 0, 0, 0, 0, 0, 6, 0));
    add(6'b001000, 6'b000000, 0, 0, 0, 4,  mk(0, 1, 0, 1, 0, 0, 0, 2, 0));
    add(6'b000010, 6'b000000, 0, 0, 0, 3,  mk(0, 2, 2, 0, 0, 0, 0, 2, 0));
    add(6'b111111, 6'b000000, 0, 0, 0, 2,  mk(0, 1, 0, 0, 0, 0, 1, 0, 0));
    add(6'b000000, 6'b000000, 0, 0, 0, 4,  mk(0, 1, 0, 1, 0, 0, 1, 7, 2));
`ifdef BNE_EN
    add(6'b000101, 6'b000000, 0, 0, 0, 3,  mk(0, 2, 1, 0, 0, 0, 0, 6, 0));
    add(6'b000101, 6'b000000, 0, 0, 1, 3,  mk(0, 1, 0, 0, 0, 0, 0, 6, 0));
`else
    add(6'b000101, 6'b000000, 1, 0, 0, 3,  mk(1, 1, 0, 0, 0, 0, 1, 0, 0));
`endif
    // reset with mem_ready high: fetch enables must stay off
    repeat (2) begin
      @(negedge clk);
      chk("rst_irwrite", {31'd0, irwrite}, 32'd0);
      chk("rst_pcen", {31'd0, pcen}, 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    foreach (tbl[i]) begin
      run(tbl[i].op, tbl[i].fn, tbl[i].f, tbl[i].m, tbl[i].z, tbl[i].n, r);
      checks++;
      if (r !== tbl[i].e) begin
        errors++;
        $display("FAIL vec%0d op=%b fn=%b got=%h exp=%h", i, tbl[i].op, tbl[i].fn, r, tbl[i].e);
      end
    end
    // sw stalled in MEMWR, then reset for 3 cycles
    op = 6'b101011;
    funct = '0;
    mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("memwr_wait_mw", {31'd0, memwrite}, 32'd1);
      chk("memwr_wait_iord", {31'd0, iord}, 32'd1);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_mw", {31'd0, memwrite}, 32'd0);
      chk("rst_mid_we", {27'd0, pcen, irwrite, regwrite_int, regwrite_float, illegal_op}, 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_irwrite", {31'd0, irwrite}, 32'd1);
    chk("post_rst_fetch_mux", {28'd0, alusrcb, iord, alusrca}, 32'h4);
    @(posedge clk);
    #1;
    repeat (3) begin @(posedge clk); #1; end
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 8))
        0: o = 6'b100011;
        1: o = 6'b101011;
        2: o = 6'b000000;
        3: o = 6'b010001;
        4: o = 6'b000100;
        5: o = 6'b001000;
        6: o = 6'b000010;
        7: o = 6'b000101;
        default: o = 6'($urandom);
      endcase
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      f = $urandom_range(0, 3);
      m = $urandom_range(0, 3);
      z = 1'($urandom);
      model(o, fn, f, m, z, n, e);
      run(o, fn, f, m, z, n, r);
      checks++;
      if (r !== e) begin
        errors++;
        $display("FAIL rnd%0d op=%b fn=%b f=%0d m=%0d z=%0d got=%h exp=%h", k, o, fn, f, m, z, r, e);
      end
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("final_fetch", {31'd0, irwrite}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
